// File: rtl/sync_filter_multi_pkg.sv
// Package sync_pkg: shared defaults and the counter-width helper used by the
// multi-channel synchronizer/debouncer. There are no ports here.
package sync_pkg;

   localparam int DEF_NUM_CH     = 4;
   localparam int DEF_NUM_STAGES = 2;
   localparam int DEF_FILTER_LEN = 4;

   // Persistence counter width: max(1, $clog2(len)). A one-bit counter is
   // kept even when FILTER_LEN is 1 or 2 so the compare logic stays uniform.
   function automatic int cnt_width(input int len);
      return (len <= 2) ? 1 : $clog2(len);
   endfunction

endpackage

// File: rtl/sync_filter_multi_if.sv
// Interface bundling the channel bus of sync_filter_multi.
//   async_in   : raw asynchronous inputs, one bit per channel
//   sync_out   : last synchronizer stage per channel (unfiltered)
//   filt_out   : debounced, accepted level per channel
//   rise_pulse : one-cycle pulse when filt_out goes 0->1
//   fall_pulse : one-cycle pulse when filt_out goes 1->0
// The master side drives async_in; the slave side (the filter) drives the rest.
// There is no handshake: every signal is a level sampled on clk.
interface sync_filter_multi_if #(
   parameter int NUM_CH = 4
);
   logic [NUM_CH-1:0] async_in;
   logic [NUM_CH-1:0] sync_out;
   logic [NUM_CH-1:0] filt_out;
   logic [NUM_CH-1:0] rise_pulse;
   logic [NUM_CH-1:0] fall_pulse;

   modport master (
      output async_in,
      input  sync_out,
      input  filt_out,
      input  rise_pulse,
      input  fall_pulse
   );

   modport slave (
      input  async_in,
      output sync_out,
      output filt_out,
      output rise_pulse,
      output fall_pulse
   );
endinterface

// File: rtl/sync_filter_chan.sv
// One channel of the synchronizer/debouncer: NUM_STAGES-deep flop chain,
// persistence counter, accepted level register and registered edge pulses.
// Ports:
//   clk        : system clock, rising edge
//   n_rst      : synchronous active-low reset
//   async_in   : raw asynchronous input bit
//   sync_out   : last chain stage
//   filt_out   : debounced level
//   rise_pulse : high for the single cycle filt_out first shows 1
//   fall_pulse : high for the single cycle filt_out first shows 0
module sync_filter_chan
   import sync_pkg::*;
#(
   parameter int   NUM_STAGES = DEF_NUM_STAGES,
   parameter int   FILTER_LEN = DEF_FILTER_LEN,
   parameter logic RESET_VAL  = 1'b0
) (
   input  logic clk,
   input  logic n_rst,
   input  logic async_in,
   output logic sync_out,
   output logic filt_out,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int CW = cnt_width(FILTER_LEN);

   if (NUM_STAGES < 2) begin : g_bad_stages
      $error("sync_filter_chan: NUM_STAGES must be at least 2");
   end
   if (FILTER_LEN < 1) begin : g_bad_filter
      $error("sync_filter_chan: FILTER_LEN must be at least 1");
   end

   // stage[0] samples the pin; stage[NUM_STAGES-1] is the synchronised bit.
   logic [NUM_STAGES-1:0] stage;
   logic [CW-1:0]         cnt;

   assign sync_out = stage[NUM_STAGES-1];

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         stage      <= {NUM_STAGES{RESET_VAL}};
         filt_out   <= RESET_VAL;
         cnt        <= '0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         stage      <= {stage[NUM_STAGES-2:0], async_in};
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         // An unknown sync_out makes this test fail, so X is counted as a
         // difference: the filter keeps moving and cannot lock up.
         if (sync_out == filt_out) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            filt_out   <= sync_out;
            cnt        <= '0;
            rise_pulse <= sync_out;
            fall_pulse <= ~sync_out;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sync_filter_multi.sv
// Multi-channel input conditioner: NUM_CH independent copies of
// sync_filter_chan, each synchronising, debouncing and edge-detecting one
// asynchronous input bit.
// Ports:
//   clk   : system clock, rising edge
//   n_rst : synchronous active-low reset
//   bus   : slave side of sync_filter_multi_if (async_in in; sync_out,
//           filt_out, rise_pulse, fall_pulse out)
module sync_filter_multi
   import sync_pkg::*;
#(
   parameter int   NUM_CH     = DEF_NUM_CH,
   parameter int   NUM_STAGES = DEF_NUM_STAGES,
   parameter int   FILTER_LEN = DEF_FILTER_LEN,
   parameter logic RESET_VAL  = 1'b0
) (
   input logic               clk,
   input logic               n_rst,
   sync_filter_multi_if.slave bus
);

   if (NUM_CH < 1) begin : g_bad_ch
      $error("sync_filter_multi: NUM_CH must be at least 1");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sync_filter_chan #(
         .NUM_STAGES (NUM_STAGES),
         .FILTER_LEN (FILTER_LEN),
         .RESET_VAL  (RESET_VAL)
      ) u_chan (
         .clk        (clk),
         .n_rst      (n_rst),
         .async_in   (bus.async_in[i]),
         .sync_out   (bus.sync_out[i]),
         .filt_out   (bus.filt_out[i]),
         .rise_pulse (bus.rise_pulse[i]),
         .fall_pulse (bus.fall_pulse[i])
      );
   end

endmodule
